// File: rtl/pipeline_hazard_controller.sv
// Stage enables, flushes, forwarding and memory watchdog for the 5-stage core.
// Optional: `define FORWARDING_EN for EX/MEM and MEM/WB operand forwarding.
module pipeline_hazard_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic          timeout_d;
  logic          stall_inc, flush_inc;
  logic          freeze, raw;
  logic [1:0]    fwd_a, fwd_b;

  function automatic logic hit(
    input logic [4:0] src,
    input logic       used,
    input logic [4:0] rd,
    input logic       we
  );
    return used && we && (rd != 5'd0) && (src == rd);
  endfunction

`ifdef FORWARDING_EN
  // Only a load in EX cannot be bypassed in time.
  assign raw = ex_mem_read &&
    (hit(id_rs1, id_uses_rs1, ex_rd, ex_reg_write) ||
     hit(id_rs2, id_uses_rs2, ex_rd, ex_reg_write));

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hit(ex_rs1, 1'b1, mem_rd, mem_reg_write))
      fwd_a = 2'b10;
    else if (hit(ex_rs1, 1'b1, wb_rd, wb_reg_write))
      fwd_a = 2'b01;
    if (hit(ex_rs2, 1'b1, mem_rd, mem_reg_write))
      fwd_b = 2'b10;
    else if (hit(ex_rs2, 1'b1, wb_rd, wb_reg_write))
      fwd_b = 2'b01;
  end
`else
  // WB producers are covered by the write-first register bank.
  assign raw =
    hit(id_rs1, id_uses_rs1, ex_rd, ex_reg_write) ||
    hit(id_rs2, id_uses_rs2, ex_rd, ex_reg_write) ||
    hit(id_rs1, id_uses_rs1, mem_rd, mem_reg_write) ||
    hit(id_rs2, id_uses_rs2, mem_rd, mem_reg_write);
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  logic unused_nofwd;
  assign unused_nofwd =
    ^{ex_rs1, ex_rs2, wb_rd, wb_reg_write, ex_mem_read};
`endif

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    forward_a    = 2'b00;
    forward_b    = 2'b00;
    state_d      = state;
    timer_d      = timer;
    timeout_d    = mem_timeout;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    freeze = (state == RUN) ? (dmem_req && !dmem_ready)
                            : !dmem_ready;
    case (state)
      RUN, MEM_WAIT: begin
        if (freeze) begin
          mem_wb_flush = 1'b1;
          stall_inc    = 1'b1;
          if (state == RUN) begin
            state_d = MEM_WAIT;
            timer_d = TW'(1);
          end else if (TIMEOUT != 0 &&
                       timer == TW'(TIMEOUT)) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer + TW'(1);
          end
        end else begin
          state_d   = RUN;
          timer_d   = '0;
          forward_a = fwd_a;
          forward_b = fwd_b;
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          // A taken branch squashes the would-be stalled instruction.
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (raw) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end
      default: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        mem_wb_flush = 1'b1;
      end
    endcase
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      forward_a    = 2'b00;
      forward_b    = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      timer       <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      mem_timeout <= timeout_d;
      if (stall_inc && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign ctrl_state = state;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequences the five-stage segmented RISC-V core by generating per-stage enable, flush and forwarding controls. It detects RAW data hazards and taken branches, and freezes the pipeline during multi-cycle data-memory accesses. A watchdog halts the core on a memory timeout. Sits beside the segmented main and jump controllers; it drives the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and the PC enable.

Parameters:
TIMEOUT, 16, maximum MEM_WAIT cycles before HALT; 0 disables the watchdog
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
id_rs1, id_rs2  in  5  source registers of the instruction in ID
id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2
ex_rs1, ex_rs2  in  5  source registers of the instruction in EX
ex_rd  in  5  destination register in EX
ex_reg_write, ex_mem_read  in  1  EX writes a register / EX is a load
mem_rd  in  5  destination register in MEM
mem_reg_write  in  1  MEM writes a register
wb_rd  in  5  destination register in WB
wb_reg_write  in  1  WB writes a register
ex_branch_taken  in  1  jump controller resolved a taken branch or jump in EX
dmem_req  in  1  MEM stage is accessing data memory
dmem_ready  in  1  data memory completes the access this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  stage register enables
if_id_flush, id_ex_flush, mem_wb_flush  out  1  insert a bubble into the stage
forward_a, forward_b  out  2  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB
mem_timeout  out  1  sticky watchdog error
ctrl_state  out  2  00 RUN, 01 MEM_WAIT, 10 HALT
stall_count, flush_count  out  CNT_W  saturating event counters

Behaviour:
- Reset (reset=0, asynchronous):
  - State RUN, wait timer 0, counters 0, mem_timeout 0.
  - While reset is asserted: all enables 0, if_id_flush=id_ex_flush=mem_wb_flush=1, forward_a=forward_b=00.
- Outputs are combinational from state and inputs; only state, timer, counters and mem_timeout are registered.
- Hazard match: rd≠0, the producer's reg_write=1, and the consumer's uses_rsX=1.
- RUN, priority order (highest first):
  1. Freeze, when dmem_req=1 and dmem_ready=0:
     - All enables 0, all flushes 0 except mem_wb_flush=1.
     - Next state MEM_WAIT, timer←1.
  2. Branch, when ex_branch_taken=1:
     - pc_en=if_id_en=id_ex_en=ex_mem_en=1, if_id_flush=id_ex_flush=1.
     - flush_count+1. Overrides a RAW stall, because the stalled instruction is squashed.
  3. RAW stall:
     - pc_en=if_id_en=0, id_ex_flush=1, id_ex_en=ex_mem_en=1.
     - stall_count+1.
  4. Otherwise all enables 1 and all flushes 0.
- MEM_WAIT:
  - dmem_ready=0: freeze as above, timer+1, stall_count+1.
  - dmem_ready=1: outputs evaluated as RUN items 2–4, next state RUN, timer←0. A branch held in EX during the wait is honoured in this cycle.
  - If TIMEOUT≠0 and timer==TIMEOUT with dmem_ready=0: next state HALT, mem_timeout←1.
- HALT:
  - All enables 0, all flushes 1, no counter updates.
  - Exits only on reset.
- Counters saturate at 2^CNT_W−1 and never wrap.
- The freeze cycle counts as a stall cycle: stall_count+1.

Optional Feature:
FORWARDING_EN
- Defined:
  - RAW stall only on load-use: ex_mem_read=1 and ex_rd matches an ID source.
  - forward_a/forward_b select 10 on an ex_rs match with mem_rd, otherwise 01 on a match with wb_rd, otherwise 00. MEM has priority over WB.
  - Forwarding outputs are held at 00 while frozen or in HALT.
- Undefined:
  - RAW stall whenever an ID source matches ex_rd or mem_rd; WB conflicts are resolved by the register bank's write-first read.
  - forward_a/forward_b are tied to 00.

Test Plan:
- Reset release:
  - Stimulus: reset=0 for 3 cycles, then 1 with no hazards.
  - Response: enables 1, flushes 0, ctrl_state=00, counters 0.
- Load-use:
  - Stimulus: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1.
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle, stall_count=1. With FORWARDING_EN, the next cycle has forward_a=10 for ex_rs1=5 against mem_rd=5.
- Branch over stall:
  - Stimulus: a RAW stall condition and ex_branch_taken=1 together.
  - Response: if_id_flush=id_ex_flush=1, pc_en=1, flush_count=1, stall_count unchanged.
- Memory wait:
  - Stimulus: dmem_req=1, dmem_ready=0 for 4 cycles, then 1.
  - Response: all enables 0 for 4 cycles, ctrl_state=01, stall_count=4, return to 00.
- Watchdog:
  - Stimulus: TIMEOUT=4, dmem_ready stuck at 0.
  - Response: HALT after 5 frozen cycles, mem_timeout=1, all flushes 1; reset clears it.
- x0 and saturation:
  - Stimulus: ex_rd=0 matching id_rs1=0.
  - Response: no stall.
  - Stimulus: CNT_W=2 with 5 stalls.
  - Response: stall_count=3.
